// File: rtl/hls_job_sequencer.sv
// hls_job_sequencer: Wishbone master that runs the HLS adder core as a job engine.
//   Takes (a, b) jobs on s_job_*, writes REG_A/REG_B, starts the core through
//   REG_CONTROL, polls REG_STATUS until idle (or MAX_POLLS reads), reads REG_C
//   and returns the result on m_result_*.
// Ports:
//   wb_rst_i, wb_clk_i           asynchronous active-low reset, clock
//   m_wb_*                       Wishbone master port toward the core's slave
//   s_job_a/b/valid/ready        operand job stream in
//   m_result_data/err/valid/ready result stream out (err = status timeout)
//   m_result_cycles              clocks from start ack to final status ack
//                                (only when HLS_SEQ_CYCLE_COUNT_EN is defined)
//   busy                         high whenever a job is in flight
// Optional feature macro: HLS_SEQ_CYCLE_COUNT_EN
module hls_job_sequencer #(
  parameter int WB_ADR_WIDTH  = 37,
  parameter int WB_DAT_WIDTH  = 64,
  parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter int DATA_WIDTH    = 32,
  parameter int HLS_BASE      = 0,
  parameter int POLL_INTERVAL = 4,
  parameter int MAX_POLLS     = 1024
) (
  input  logic                    wb_rst_i,
  input  logic                    wb_clk_i,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic                    m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_job_a,
  input  logic [DATA_WIDTH-1:0]   s_job_b,
  input  logic                    s_job_valid,
  output logic                    s_job_ready,
  output logic [DATA_WIDTH-1:0]   m_result_data,
  output logic                    m_result_err,
  output logic                    m_result_valid,
  input  logic                    m_result_ready,
`ifdef HLS_SEQ_CYCLE_COUNT_EN
  output logic [31:0]             m_result_cycles,
`endif
  output logic                    busy
);
  localparam int PW = MAX_POLLS == 0 ? 1 : $clog2(MAX_POLLS + 1);
  localparam int WW = POLL_INTERVAL < 2 ? 1 : $clog2(POLL_INTERVAL);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);
  localparam logic [WW-1:0] WAIT_LAST = WW'(POLL_INTERVAL == 0 ? 0 : POLL_INTERVAL - 1);
  localparam logic [WB_ADR_WIDTH-1:0] BASE    = WB_ADR_WIDTH'(HLS_BASE);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL = BASE + WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STS = BASE + WB_ADR_WIDTH'(5);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_A   = BASE + WB_ADR_WIDTH'(8);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_B   = BASE + WB_ADR_WIDTH'(9);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_C   = BASE + WB_ADR_WIDTH'(10);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_START, POLL_WAIT, RD_STATUS, RD_C, OUT} state_t;

  state_t                  state_q, state_d;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic                    we_q, we_d, stb_q, stb_d;
  logic                    job_ready_q, job_ready_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d, res_data_q, res_data_d;
  logic                    res_err_q, res_err_d, res_valid_q, res_valid_d;
  logic [PW-1:0]           poll_q, poll_d, poll_inc;
  logic [WW-1:0]           wait_q, wait_d;
  logic                    accept, ack_ok, timeout, issue, unused_dat;
  state_t                  poll_next;
`ifdef HLS_SEQ_CYCLE_COUNT_EN
  logic [31:0]             cyc_q, cyc_d;
`endif

  assign accept     = state_q == IDLE && s_job_valid && job_ready_q;
  assign ack_ok     = stb_q && m_wb_ack_i;
  assign poll_inc   = poll_q + 1'b1;
  assign timeout    = MAX_POLLS != 0 && poll_inc == POLL_LIMIT;
  assign poll_next  = POLL_INTERVAL == 0 ? RD_STATUS : POLL_WAIT;
  assign unused_dat = ^m_wb_dat_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      job_ready_q <= 1'b0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      poll_q      <= '0;
      wait_q      <= '0;
`ifdef HLS_SEQ_CYCLE_COUNT_EN
      cyc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      job_ready_q <= job_ready_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      poll_q      <= poll_d;
      wait_q      <= wait_d;
`ifdef HLS_SEQ_CYCLE_COUNT_EN
      cyc_q       <= cyc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = accept ? WR_A : IDLE;
      WR_A:      state_d = ack_ok ? WR_B : WR_A;
      WR_B:      state_d = ack_ok ? WR_START : WR_B;
      WR_START:  state_d = ack_ok ? poll_next : WR_START;
      POLL_WAIT: state_d = wait_q == WAIT_LAST ? RD_STATUS : POLL_WAIT;
      RD_STATUS: state_d = !ack_ok ? RD_STATUS : !m_wb_dat_i[0] ? RD_C : timeout ? OUT : poll_next;
      RD_C:      state_d = ack_ok ? OUT : RD_C;
      OUT:       state_d = m_result_ready ? IDLE : OUT;
      default:   state_d = IDLE;
    endcase
  end

  // A new bus cycle is only launched from a cycle with stb low, so every
  // ack is followed by at least one idle cycle before the next strobe.
  always_comb begin
    issue       = !stb_q && (state_d inside {WR_A, WR_B, WR_START, RD_STATUS, RD_C});
    stb_d       = (stb_q && !m_wb_ack_i) || issue;
    adr_d       = !issue ? adr_q :
                  state_d == WR_A ? ADR_A :
                  state_d == WR_B ? ADR_B :
                  state_d == WR_START ? ADR_CTL :
                  state_d == RD_STATUS ? ADR_STS : ADR_C;
    we_d        = issue ? state_d inside {WR_A, WR_B, WR_START} : we_q;
    dat_d       = !issue ? dat_q :
                  state_d == WR_A ? WB_DAT_WIDTH'(s_job_a) :
                  state_d == WR_B ? WB_DAT_WIDTH'(b_q) :
                  state_d == WR_START ? WB_DAT_WIDTH'(1) : '0;
    job_ready_d = state_d == IDLE;
    b_d         = accept ? s_job_b : b_q;
    poll_d      = accept ? '0 : (state_q == RD_STATUS && ack_ok) ? poll_inc : poll_q;
    wait_d      = state_q == POLL_WAIT ? wait_q + 1'b1 : '0;
    res_valid_d = state_d == OUT;
    res_data_d  = (state_q == RD_C && ack_ok) ? m_wb_dat_i[DATA_WIDTH-1:0] :
                  (state_q == RD_STATUS && state_d == OUT) ? '0 : res_data_q;
    res_err_d   = (state_q == RD_C && ack_ok) ? 1'b0 :
                  (state_q == RD_STATUS && state_d == OUT) ? 1'b1 : res_err_q;
`ifdef HLS_SEQ_CYCLE_COUNT_EN
    cyc_d       = accept ? '0 :
                  (state_q inside {POLL_WAIT, RD_STATUS} && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
`endif
  end

  assign m_wb_adr_o     = adr_q;
  assign m_wb_dat_o     = dat_q;
  assign m_wb_we_o      = we_q;
  assign m_wb_stb_o     = stb_q;
  assign m_wb_sel_o     = '1;
  assign s_job_ready    = job_ready_q;
  assign m_result_data  = res_data_q;
  assign m_result_err   = res_err_q;
  assign m_result_valid = res_valid_q;
  assign busy           = state_q != IDLE;
`ifdef HLS_SEQ_CYCLE_COUNT_EN
  assign m_result_cycles = cyc_q;
`endif
endmodule
